// File: rtl/sdram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sdram_arb_pkg
//   Shared definitions for the two-port SDRAM arbiter:
//     state_e          - arbiter FSM states (IDLE, ISSUE, DONE)
//     PORT_FETCH/MEM   - requester indices (0 = instruction fetch, 1 = MEM stage)
//     DEFAULT_*        - default parameter values for the arbiter
// ---------------------------------------------------------------------------
package sdram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam logic PORT_FETCH = 1'b0;
   localparam logic PORT_MEM   = 1'b1;

   localparam int unsigned DEFAULT_AWIDTH  = 25;
   localparam int unsigned DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/sdram_arbiter_if.sv
// ---------------------------------------------------------------------------
// sdram_arbiter_if
//   Bundles the requester handshakes and the SDRAM controller port of the
//   arbiter.
//     pN_req/wr/addr/wr_data      - requester N command (level request)
//     pN_rd_data/ack/err          - requester N completion (one-cycle ack)
//     sdram_rd_req/wr_req/addr/wr_data - command to the SDRAM controller
//     sdram_rd_data/rd_ack/wr_ack      - completion from the SDRAM controller
//   Modports:
//     slave  - the arbiter
//     master - requesters plus SDRAM controller (environment side)
// ---------------------------------------------------------------------------
interface sdram_arbiter_if #(
   parameter int unsigned AWIDTH = 25
);
   logic              p0_req;
   logic              p0_wr;
   logic [AWIDTH-1:0] p0_addr;
   logic [31:0]       p0_wr_data;
   logic [31:0]       p0_rd_data;
   logic              p0_ack;
   logic              p0_err;

   logic              p1_req;
   logic              p1_wr;
   logic [AWIDTH-1:0] p1_addr;
   logic [31:0]       p1_wr_data;
   logic [31:0]       p1_rd_data;
   logic              p1_ack;
   logic              p1_err;

   logic              sdram_rd_req;
   logic              sdram_wr_req;
   logic [AWIDTH-1:0] sdram_addr;
   logic [31:0]       sdram_wr_data;
   logic [31:0]       sdram_rd_data;
   logic              sdram_rd_ack;
   logic              sdram_wr_ack;

   modport slave (
      input  p0_req, p0_wr, p0_addr, p0_wr_data,
      output p0_rd_data, p0_ack, p0_err,
      input  p1_req, p1_wr, p1_addr, p1_wr_data,
      output p1_rd_data, p1_ack, p1_err,
      output sdram_rd_req, sdram_wr_req, sdram_addr, sdram_wr_data,
      input  sdram_rd_data, sdram_rd_ack, sdram_wr_ack
   );

   modport master (
      output p0_req, p0_wr, p0_addr, p0_wr_data,
      input  p0_rd_data, p0_ack, p0_err,
      output p1_req, p1_wr, p1_addr, p1_wr_data,
      input  p1_rd_data, p1_ack, p1_err,
      input  sdram_rd_req, sdram_wr_req, sdram_addr, sdram_wr_data,
      output sdram_rd_data, sdram_rd_ack, sdram_wr_ack
   );

endinterface

// File: rtl/sdram_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// sdram_rr_pick
//   Combinational two-way round-robin selector.
//     req_i[1:0] - pending requests (bit N = port N)
//     last_i     - port granted by the previous transaction
//     valid_o    - at least one request pending
//     grant_o    - chosen port; on contention the port that did not go last
// ---------------------------------------------------------------------------
module sdram_rr_pick (
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic       valid_o,
   output logic       grant_o
);

   always_comb begin
      valid_o = |req_i;
      grant_o = 1'b0;
      if (req_i == 2'b11) begin
         grant_o = ~last_i;
      end else begin
         grant_o = req_i[1];
      end
   end

endmodule

// File: rtl/sdram_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_arbiter
//   Shares one SDRAM controller port between instruction fetch (port 0) and
//   MEM-stage data access (port 1). One transaction at a time, round-robin on
//   contention, with a watchdog that aborts unacknowledged transactions.
//   Ports:
//     CLK   - clock
//     RST_X - synchronous active-low reset
//     bus   - requester handshakes and SDRAM controller port (slave side)
//   Parameters:
//     AWIDTH  - SDRAM word address width
//     TIMEOUT - ISSUE cycles allowed before abort (>= 2)
// ---------------------------------------------------------------------------
module sdram_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int unsigned AWIDTH  = DEFAULT_AWIDTH,
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic            CLK,
   input  logic            RST_X,
   sdram_arbiter_if.slave  bus
);

   localparam int unsigned    TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0]  TLAST = TW'(TIMEOUT - 1);

   state_e            state_q;
   logic              last_q;
   logic              gnt_q;
   logic              wr_q;
   logic [AWIDTH-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [TW-1:0]     timer_q;
   logic              rd_req_q;
   logic              wr_req_q;
   logic              ack0_q;
   logic              ack1_q;
   logic              err0_q;
   logic              err1_q;
   logic [31:0]       rd0_q;
   logic [31:0]       rd1_q;

   logic              pick_valid;
   logic              pick_grant;
   logic              sel_wr;
   logic [AWIDTH-1:0] sel_addr;
   logic [31:0]       sel_wdata;
   logic              ack_hit;
   logic              timeout_hit;

   sdram_rr_pick u_pick (
      .req_i   ({bus.p1_req, bus.p0_req}),
      .last_i  (last_q),
      .valid_o (pick_valid),
      .grant_o (pick_grant)
   );

   always_comb begin
      sel_wr    = pick_grant ? bus.p1_wr      : bus.p0_wr;
      sel_addr  = pick_grant ? bus.p1_addr    : bus.p0_addr;
      sel_wdata = pick_grant ? bus.p1_wr_data : bus.p0_wr_data;
      // Only the ack belonging to the latched operation counts.
      ack_hit     = wr_q ? bus.sdram_wr_ack : bus.sdram_rd_ack;
      timeout_hit = (timer_q == TLAST);
   end

   always_ff @(posedge CLK) begin
      if (!RST_X) begin
         state_q  <= IDLE;
         last_q   <= PORT_MEM;
         gnt_q    <= PORT_FETCH;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         timer_q  <= '0;
         rd_req_q <= 1'b0;
         wr_req_q <= 1'b0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         err0_q   <= 1'b0;
         err1_q   <= 1'b0;
         rd0_q    <= '0;
         rd1_q    <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (pick_valid) begin
                  gnt_q    <= pick_grant;
                  wr_q     <= sel_wr;
                  addr_q   <= sel_addr;
                  wdata_q  <= sel_wdata;
                  timer_q  <= '0;
                  rd_req_q <= ~sel_wr;
                  wr_req_q <= sel_wr;
                  state_q  <= ISSUE;
               end
            end
            ISSUE: begin
               // An ack on the final watchdog cycle still completes normally.
               if (ack_hit || timeout_hit) begin
                  rd_req_q <= 1'b0;
                  wr_req_q <= 1'b0;
                  state_q  <= DONE;
                  if (gnt_q == PORT_MEM) begin
                     ack1_q <= 1'b1;
                     err1_q <= ~ack_hit;
                     if (ack_hit && !wr_q) begin
                        rd1_q <= bus.sdram_rd_data;
                     end
                  end else begin
                     ack0_q <= 1'b1;
                     err0_q <= ~ack_hit;
                     if (ack_hit && !wr_q) begin
                        rd0_q <= bus.sdram_rd_data;
                     end
                  end
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            DONE: begin
               ack0_q  <= 1'b0;
               ack1_q  <= 1'b0;
               err0_q  <= 1'b0;
               err1_q  <= 1'b0;
               last_q  <= gnt_q;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.sdram_rd_req  = rd_req_q;
   assign bus.sdram_wr_req  = wr_req_q;
   assign bus.sdram_addr    = addr_q;
   assign bus.sdram_wr_data = wdata_q;
   assign bus.p0_ack        = ack0_q;
   assign bus.p0_err        = err0_q;
   assign bus.p0_rd_data    = rd0_q;
   assign bus.p1_ack        = ack1_q;
   assign bus.p1_err        = err1_q;
   assign bus.p1_rd_data    = rd1_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_arbiter
//   Directed bench for sdram_arbiter (TIMEOUT = 8): a table of single
//   transactions plus hand-written sequences for contention, reset during
//   ISSUE and address changes after grant.
// ---------------------------------------------------------------------------
module tb_sdram_arbiter;
   import sdram_arb_pkg::*;

   localparam int unsigned AW = 25;
   localparam int unsigned TO = 8;

   logic CLK = 1'b0;
   logic RST_X;

   always #5 CLK = ~CLK;

   sdram_arbiter_if #(.AWIDTH(AW)) bus ();

   sdram_arbiter #(.AWIDTH(AW), .TIMEOUT(TO)) dut (
      .CLK   (CLK),
      .RST_X (RST_X),
      .bus   (bus)
   );

   typedef struct {
      logic          port;
      logic          wr;
      logic [AW-1:0] addr;
      logic [31:0]   wdata;
      int unsigned   ack_at;      // ISSUE cycle carrying the SDRAM ack, 0 = never
      logic          both;        // raise rd_ack and wr_ack together
      logic [31:0]   sd_rdata;
      int unsigned   exp_cycles;  // cycles with an SDRAM request high
      logic          exp_err;
      logic [31:0]   exp_rd0;
      logic [31:0]   exp_rd1;
   } vec_t;

   vec_t vecs[8];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.p0_req = 1'b0; bus.p0_wr = 1'b0; bus.p0_addr = '0; bus.p0_wr_data = '0;
      bus.p1_req = 1'b0; bus.p1_wr = 1'b0; bus.p1_addr = '0; bus.p1_wr_data = '0;
      bus.sdram_rd_data = '0; bus.sdram_rd_ack = 1'b0; bus.sdram_wr_ack = 1'b0;
   endtask

   function automatic logic [127:0] all_outputs();
      return {bus.p0_ack, bus.p0_err, bus.p1_ack, bus.p1_err,
              bus.sdram_rd_req, bus.sdram_wr_req, bus.sdram_addr,
              bus.sdram_wr_data, bus.p0_rd_data, bus.p1_rd_data};
   endfunction

   // Starts and ends at a negedge with the arbiter idle.
   task automatic run_txn(input string name, input vec_t v, input bit mutate);
      int unsigned req_cyc   = 0;
      int unsigned bad_op    = 0;
      int unsigned bad_addr  = 0;
      int unsigned other_ack = 0;
      logic        ack_seen  = 1'b0;
      logic        err_seen  = 1'b0;
      if (v.port == PORT_FETCH) begin
         bus.p0_req = 1'b1; bus.p0_wr = v.wr; bus.p0_addr = v.addr; bus.p0_wr_data = v.wdata;
      end else begin
         bus.p1_req = 1'b1; bus.p1_wr = v.wr; bus.p1_addr = v.addr; bus.p1_wr_data = v.wdata;
      end
      for (int unsigned c = 1; c <= 24 && !ack_seen; c++) begin
         @(negedge CLK);
         if (v.port == PORT_FETCH ? bus.p1_ack : bus.p0_ack) other_ack++;
         if (v.port == PORT_FETCH ? bus.p0_ack : bus.p1_ack) begin
            ack_seen = 1'b1;
            err_seen = (v.port == PORT_FETCH) ? bus.p0_err : bus.p1_err;
            bus.p0_req = 1'b0; bus.p1_req = 1'b0;
            bus.sdram_rd_ack = 1'b0; bus.sdram_wr_ack = 1'b0;
         end else begin
            if (bus.sdram_rd_req || bus.sdram_wr_req) begin
               req_cyc++;
               if ({bus.sdram_wr_req, bus.sdram_rd_req} != {v.wr, ~v.wr}) bad_op++;
               if (bus.sdram_addr != v.addr || bus.sdram_wr_data != v.wdata) bad_addr++;
            end
            if (mutate && c == 2) begin
               if (v.port == PORT_FETCH) begin
                  bus.p0_addr = ~v.addr; bus.p0_wr_data = ~v.wdata;
               end else begin
                  bus.p1_addr = ~v.addr; bus.p1_wr_data = ~v.wdata;
               end
            end
            if (c == v.ack_at) begin
               bus.sdram_rd_data = v.sd_rdata;
               bus.sdram_wr_ack  = v.wr | v.both;
               bus.sdram_rd_ack  = ~v.wr | v.both;
            end else begin
               bus.sdram_rd_ack = 1'b0; bus.sdram_wr_ack = 1'b0;
            end
         end
      end
      bus.p0_req = 1'b0; bus.p1_req = 1'b0;
      bus.sdram_rd_ack = 1'b0; bus.sdram_wr_ack = 1'b0;
      check({name, "_ack_seen"},   ack_seen,  1'b1);
      check({name, "_req_cycles"}, req_cyc,   v.exp_cycles);
      check({name, "_op_kind"},    bad_op,    0);
      check({name, "_latched"},    bad_addr,  0);
      check({name, "_other_ack"},  other_ack, 0);
      check({name, "_err"},        err_seen,  v.exp_err);
      @(negedge CLK);
      check({name, "_ack_pulse"},  {bus.p0_ack, bus.p1_ack, bus.p0_err, bus.p1_err}, 4'b0);
      check({name, "_rd0"},        bus.p0_rd_data, v.exp_rd0);
      check({name, "_rd1"},        bus.p1_rd_data, v.exp_rd1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1);
   end

   initial begin
      logic        grants[$];
      logic [31:0] exp_rd0;
      int unsigned rd_seq;
      int unsigned bad_b;
      int unsigned stray_ack;
      vec_t        vd;

      vecs[0] = '{PORT_FETCH, 1'b0, 25'h0000100, 32'h0,          3, 1'b0, 32'hCAFEBABE, 3, 1'b0, 32'hCAFEBABE, 32'h0};
      vecs[1] = '{PORT_MEM,   1'b1, 25'h0000020, 32'h12345678,   1, 1'b0, 32'h0,        1, 1'b0, 32'hCAFEBABE, 32'h0};
      vecs[2] = '{PORT_MEM,   1'b1, 25'h0ABCDEF, 32'hFEEDFACE,   2, 1'b1, 32'hDEADDEAD, 2, 1'b0, 32'hCAFEBABE, 32'h0};
      vecs[3] = '{PORT_FETCH, 1'b0, 25'h1FFFFFF, 32'h0,          0, 1'b0, 32'h0,        8, 1'b1, 32'hCAFEBABE, 32'h0};
      vecs[4] = '{PORT_FETCH, 1'b0, 25'h0000004, 32'h0,          1, 1'b0, 32'h0BADF00D, 1, 1'b0, 32'h0BADF00D, 32'h0};
      vecs[5] = '{PORT_MEM,   1'b0, 25'h1234567, 32'h0,          5, 1'b0, 32'h55AA55AA, 5, 1'b0, 32'h0BADF00D, 32'h55AA55AA};
      vecs[6] = '{PORT_MEM,   1'b1, 25'h0000020, 32'hA5A5A5A5,   2, 1'b0, 32'h11111111, 2, 1'b0, 32'h0BADF00D, 32'h55AA55AA};
      vecs[7] = '{PORT_FETCH, 1'b1, 25'h0000008, 32'h0F0F0F0F,   8, 1'b0, 32'h0,        8, 1'b0, 32'h0BADF00D, 32'h55AA55AA};

      RST_X = 1'b0;
      clear_inputs();
      repeat (3) @(negedge CLK);
      check("reset_outputs", all_outputs(), '0);
      check("reset_state", dut.state_q, IDLE);
      RST_X = 1'b1;

      foreach (vecs[i]) begin
         run_txn($sformatf("v%0d", i), vecs[i], 1'b0);
      end

      // Reset while port 1 read is in ISSUE: abandoned, no ack.
      bus.p1_req = 1'b1; bus.p1_wr = 1'b0; bus.p1_addr = 25'h0000333;
      repeat (2) @(negedge CLK);
      check("rst_mid_rd_req", bus.sdram_rd_req, 1'b1);
      RST_X = 1'b0;
      bus.p1_req = 1'b0;
      @(negedge CLK);
      check("rst_mid_outputs", all_outputs(), '0);
      check("rst_mid_state", dut.state_q, IDLE);
      stray_ack = 0;
      @(negedge CLK);
      if (bus.p0_ack || bus.p1_ack) stray_ack++;

      // Release reset and request from both ports in the same cycle.
      RST_X = 1'b1;
      bus.p0_req = 1'b1; bus.p0_wr = 1'b0; bus.p0_addr = 25'h0000010; bus.p0_wr_data = 32'h0;
      bus.p1_req = 1'b1; bus.p1_wr = 1'b1; bus.p1_addr = 25'h0000020; bus.p1_wr_data = 32'h12345678;
      rd_seq  = 0;
      bad_b   = 0;
      exp_rd0 = 32'h0;
      for (int unsigned c = 0; c < 60 && grants.size() < 4; c++) begin
         @(negedge CLK);
         if (bus.p0_ack) grants.push_back(PORT_FETCH);
         if (bus.p1_ack) grants.push_back(PORT_MEM);
         if (grants.size() >= 4) begin
            bus.p0_req = 1'b0; bus.p1_req = 1'b0;
         end
         if (bus.sdram_rd_req && !bus.sdram_wr_req) begin
            if (bus.sdram_addr != 25'h0000010) bad_b++;
            rd_seq++;
            exp_rd0 = 32'hA0000000 + rd_seq;
            bus.sdram_rd_data = exp_rd0;
            bus.sdram_rd_ack  = 1'b1;
            bus.sdram_wr_ack  = 1'b0;
         end else if (bus.sdram_wr_req && !bus.sdram_rd_req) begin
            if (bus.sdram_addr != 25'h0000020 || bus.sdram_wr_data != 32'h12345678) bad_b++;
            bus.sdram_wr_ack = 1'b1;
            bus.sdram_rd_ack = 1'b0;
         end else begin
            bus.sdram_rd_ack = 1'b0; bus.sdram_wr_ack = 1'b0;
         end
      end
      bus.p0_req = 1'b0; bus.p1_req = 1'b0;
      bus.sdram_rd_ack = 1'b0; bus.sdram_wr_ack = 1'b0;
      check("rst_no_ack", stray_ack, 0);
      check("both_grant_count", grants.size(), 4);
      while (grants.size() < 4) grants.push_back(1'bx);
      check("both_grant_order", {grants[0], grants[1], grants[2], grants[3]}, 4'b0101);
      check("both_latched", bad_b, 0);
      @(negedge CLK);
      check("both_rd0", bus.p0_rd_data, exp_rd0);
      check("both_rd0_value", exp_rd0, 32'hA0000002);
      check("both_rd1", bus.p1_rd_data, 32'h0);

      // Address/data change after grant must not reach the SDRAM port.
      vd = '{PORT_FETCH, 1'b0, 25'h0000100, 32'h00000000, 4, 1'b0, 32'h13579BDF, 4, 1'b0, 32'h13579BDF, 32'h0};
      run_txn("addr_change", vd, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
